// File: rtl/meteo_disp_mux.sv
// Display front-end for the meteo station: picks one measurement channel (manual or timed rotation),
// converts it to BCD by sequential double-dabble and drives active-low 7-segment digits.
module meteo_disp_mux #(
    parameter int NCH   = 3,
    parameter int SELW  = 2,
    parameter int W     = 32,
    parameter int NDIG  = 6,
    parameter int DWELL = 100000000
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NCH*W-1:0]  Values_i,
    input  logic [NCH-1:0]    Valid_i,
    input  logic              Auto_i,
    input  logic [SELW-1:0]   Sel_i,
    input  logic              Blank_i,
    output logic [NDIG*7-1:0] Dec_o,
    output logic [SELW-1:0]   Ch_o,
    output logic              Overflow_o,
    output logic              Busy_o
);

    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW  = $clog2(W + 1);
    localparam int BW  = 4 * NDIG;
    localparam logic [SELW:0]   NCH_L   = (SELW + 1)'(NCH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

    state_t             state_q, state_d;
    logic [SELW-1:0]    ch_q, ch_next;
    logic [DCW-1:0]     dwell_q, dwell_d;
    logic               auto_q;
    logic               init_q;
    logic               pending_q;
    logic [W-1:0]       opnd_q;
    logic [BW-1:0]      bcd_q, bcd_adj;
    logic               ovf_q;
    logic [IW-1:0]      iter_q;
    logic [NDIG*7-1:0]  dec_q, dec_enc;
    logic               ovf_out_q;
    logic               ch_change, valid_hit, load;
    logic               busy, do_iter, do_commit;
    logic               lead;
    logic [3:0]         digit;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Channel selection; the dwell counter only runs once auto mode has been seen for a full cycle,
    // so enabling rotation always starts a fresh DWELL period on the current channel.
    always_comb begin
        ch_next = ch_q;
        dwell_d = dwell_q;
        if (!Auto_i) begin
            dwell_d = '0;
            if ({1'b0, Sel_i} < NCH_L)
                ch_next = Sel_i;
        end else if (!auto_q) begin
            dwell_d = '0;
        end else if (dwell_q == DCW'(DWELL - 1)) begin
            dwell_d = '0;
            ch_next = (ch_q == LAST_CH) ? '0 : ch_q + SELW'(1);
        end else begin
            dwell_d = dwell_q + DCW'(1);
        end
    end

    assign ch_change = (ch_next != ch_q);
    assign valid_hit = Valid_i[ch_q];
    assign load      = init_q | ch_change | ((state_q == S_IDLE) & (valid_hit | pending_q));

    always_ff @(posedge Clk) begin
        if (Rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = S_SHIFT;
        end else begin
            case (state_q)
                S_SHIFT:  if (iter_q == IW'(W - 1)) state_d = S_COMMIT;
                S_COMMIT: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // A reload on the same edge always wins over an iteration or a commit.
    always_comb begin
        busy      = 1'b0;
        do_iter   = 1'b0;
        do_commit = 1'b0;
        case (state_q)
            S_SHIFT: begin
                busy    = 1'b1;
                do_iter = ~load;
            end
            S_COMMIT: begin
                busy      = 1'b1;
                do_commit = ~load;
            end
            default: ;
        endcase
    end

    always_comb begin
        bcd_adj = '0;
        for (int d = 0; d < NDIG; d++)
            bcd_adj[4*d +: 4] = (bcd_q[4*d +: 4] >= 4'd5) ? bcd_q[4*d +: 4] + 4'd3 : bcd_q[4*d +: 4];
    end

    // Leading-zero blanking walks down from the top digit until the first non-zero one.
    always_comb begin
        dec_enc = '0;
        lead    = Blank_i;
        digit   = '0;
        for (int d = NDIG - 1; d >= 0; d--) begin
            digit = bcd_q[4*d +: 4];
            if (ovf_q) begin
                dec_enc[7*d +: 7] = 7'b0111111;
            end else if (lead && (d != 0) && (digit == 4'd0)) begin
                dec_enc[7*d +: 7] = 7'h7F;
            end else begin
                dec_enc[7*d +: 7] = seg7(digit);
                lead = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ch_q      <= '0;
            dwell_q   <= '0;
            auto_q    <= 1'b0;
            init_q    <= 1'b1;
            pending_q <= 1'b0;
            opnd_q    <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            iter_q    <= '0;
            dec_q     <= {NDIG{7'h7F}};
            ovf_out_q <= 1'b0;
        end else begin
            ch_q    <= ch_next;
            dwell_q <= dwell_d;
            auto_q  <= Auto_i;
            init_q  <= 1'b0;
            if (load) begin
                opnd_q    <= Values_i[ch_next*W +: W];
                bcd_q     <= '0;
                ovf_q     <= 1'b0;
                iter_q    <= '0;
                pending_q <= 1'b0;
            end else begin
                if (busy && valid_hit)
                    pending_q <= 1'b1;
                if (do_iter) begin
                    opnd_q <= {opnd_q[W-2:0], 1'b0};
                    bcd_q  <= {bcd_adj[BW-2:0], opnd_q[W-1]};
                    ovf_q  <= ovf_q | bcd_adj[BW-1];
                    iter_q <= iter_q + IW'(1);
                end
                if (do_commit) begin
                    dec_q     <= dec_enc;
                    ovf_out_q <= ovf_q;
                end
            end
        end
    end

    assign Dec_o      = dec_q;
    assign Ch_o       = ch_q;
    assign Overflow_o = ovf_out_q;
    assign Busy_o     = busy;

endmodule

// File: tb/tb_meteo_disp_mux.sv
// Bench for meteo_disp_mux: a decimal-arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed digit patterns.
module tb_meteo_disp_mux;

    localparam int NCH   = 3;
    localparam int SELW  = 2;
    localparam int W     = 32;
    localparam int NDIG  = 6;
    localparam int DWELL = 50;
    localparam longint unsigned LIMIT = 64'd999999;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] DS = 7'b0111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [W-1:0]       chv [NCH];
    logic [NCH*W-1:0]   values;
    logic [NCH-1:0]     valid = '0;
    logic               auto_en = 1'b0;
    logic [SELW-1:0]    sel = '0;
    logic               blank = 1'b1;
    logic [NDIG*7-1:0]  dec;
    logic [SELW-1:0]    ch;
    logic               ovf;
    logic               busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        values = '0;
        for (int c = 0; c < NCH; c++)
            values[c*W +: W] = chv[c];
    end

    meteo_disp_mux #(.NCH(NCH), .SELW(SELW), .W(W), .NDIG(NDIG), .DWELL(DWELL)) dut (
        .Clk(clk), .Rst(rst), .Values_i(values), .Valid_i(valid), .Auto_i(auto_en),
        .Sel_i(sel), .Blank_i(blank), .Dec_o(dec), .Ch_o(ch), .Overflow_o(ovf), .Busy_o(busy)
    );

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: seg_of = S0;         1: seg_of = S1;         2: seg_of = S2;
            3: seg_of = S3;         4: seg_of = S4;         5: seg_of = S5;
            6: seg_of = 7'b0000010; 7: seg_of = 7'b1111000; 8: seg_of = S8;
            9: seg_of = S9;         default: seg_of = BL;
        endcase
    endfunction

    // Expected display of a value, derived by decimal division rather than BCD shifting.
    function automatic logic [NDIG*7-1:0] expect_disp(input longint unsigned v, input logic bl);
        logic [NDIG*7-1:0] r;
        int digs [NDIG];
        int msd;
        longint unsigned t;
        r = '0;
        if (v > LIMIT) return {NDIG{DS}};
        t = v;
        msd = 0;
        for (int d = 0; d < NDIG; d++) begin
            digs[d] = int'(t % 10);
            t = t / 10;
            if (digs[d] != 0) msd = d;
        end
        for (int d = 0; d < NDIG; d++)
            r[7*d +: 7] = (bl && d > msd) ? BL : seg_of(digs[d]);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int              m_ch = 0, m_dwell = 0, m_left = 0, nch = 0;
    logic            m_auto_prev = 0, m_init = 0, m_pending = 0, m_busy = 0, m_ovf = 0, vhit = 0;
    logic [NDIG*7-1:0] m_disp = '0;
    longint unsigned m_val = 0;
    bit              model_on = 0;

    // Reference model: a conversion is a countdown of W+1 edges ending in a decimal display update.
    always @(posedge clk) begin
        model_on = 1;
        if (rst) begin
            m_ch = 0; m_dwell = 0; m_left = 0; m_auto_prev = 0; m_init = 1;
            m_pending = 0; m_busy = 0; m_ovf = 0; m_disp = {NDIG{BL}};
        end else begin
            nch = m_ch;
            if (!auto_en) begin
                m_dwell = 0;
                if (int'(sel) < NCH) nch = int'(sel);
            end else if (!m_auto_prev) begin
                m_dwell = 0;
            end else if (m_dwell == DWELL - 1) begin
                m_dwell = 0;
                nch = (m_ch + 1) % NCH;
            end else begin
                m_dwell++;
            end
            vhit = valid[m_ch];
            if (m_init || nch != m_ch || (!m_busy && (vhit || m_pending))) begin
                m_val = longint'(chv[nch]);
                m_busy = 1; m_left = W + 1; m_pending = 0;
            end else if (m_busy) begin
                if (vhit) m_pending = 1;
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_ovf  = (m_val > LIMIT);
                    m_disp = expect_disp(m_val, blank);
                end
            end
            m_ch = nch; m_init = 0; m_auto_prev = auto_en;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("model_ch", 64'(ch), 64'(m_ch));
            checkOutput("model_busy", 64'(busy), 64'(m_busy));
            checkOutput("model_ovf", 64'(ovf), 64'(m_ovf));
            checkOutput("model_dec", 64'(dec), 64'(m_disp));
        end
    end

    // Inputs change right after a falling edge; a non-zero strobe lasts exactly one cycle.
    task automatic applyStimulus(input logic [SELW-1:0] s, input logic a, input logic b, input logic [NCH-1:0] v);
        sel = s; auto_en = a; blank = b; valid = v;
        if (v != '0) begin
            @(negedge clk);
            valid = '0;
        end
    endtask

    task automatic waitBusy(input logic want, input string name);
        int n = 0;
        while (busy !== want && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 64'(busy), 64'(want));
    endtask

    task automatic waitCh(input logic [SELW-1:0] want, input string name, output int n);
        n = 0;
        while (ch !== want && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 64'(ch), 64'(want));
    endtask

    initial begin
        int cnt;
        int gap;
        logic seen_old;
        chv[0] = 2315; chv[1] = 0; chv[2] = 0;
        rst = 1;
        applyStimulus(2'd0, 1'b0, 1'b1, '0);
        repeat (3) @(negedge clk);
        checkOutput("rst_dec", 64'(dec), 64'({NDIG{BL}}));
        checkOutput("rst_ch", 64'(ch), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_ovf", 64'(ovf), 64'd0);

        // Post-reset conversion of channel 0.
        rst = 0;
        cnt = 0;
        repeat (40) begin @(negedge clk); if (busy) cnt++; end
        checkOutput("t1_busy_len", 64'(cnt), 64'd33);
        checkOutput("t1_dec", 64'(dec), 64'({BL, BL, S2, S3, S1, S5}));
        checkOutput("t1_ovf", 64'(ovf), 64'd0);

        chv[1] = 1000000;
        applyStimulus(2'd1, 1'b0, 1'b1, '0);
        waitBusy(1'b1, "t2_start");
        waitBusy(1'b0, "t2_done");
        checkOutput("t2_dash", 64'(dec), 64'({NDIG{DS}}));
        checkOutput("t2_ovf", 64'(ovf), 64'd1);
        checkOutput("t2_ch", 64'(ch), 64'd1);
        chv[1] = 999999;
        applyStimulus(2'd1, 1'b0, 1'b1, 3'b010);
        waitBusy(1'b0, "t2b_done");
        checkOutput("t2_nines", 64'(dec), 64'({NDIG{S9}}));
        checkOutput("t2_ovf_clr", 64'(ovf), 64'd0);

        chv[0] = 42;
        applyStimulus(2'd0, 1'b0, 1'b0, '0);
        waitBusy(1'b1, "t3_start");
        waitBusy(1'b0, "t3_done");
        checkOutput("t3_noblank", 64'(dec), 64'({S0, S0, S0, S0, S4, S2}));
        chv[0] = 0;
        applyStimulus(2'd0, 1'b0, 1'b1, 3'b001);
        waitBusy(1'b0, "t3b_done");
        checkOutput("t3_zero", 64'(dec), 64'({BL, BL, BL, BL, BL, S0}));

        // Auto-rotation: the first change comes DWELL edges after the enabling edge.
        chv[0] = 111; chv[1] = 222222; chv[2] = 3;
        applyStimulus(2'd0, 1'b1, 1'b1, '0);
        waitCh(2'd1, "t4_ch1", gap);
        checkOutput("t4_first_gap", 64'(gap), 64'd51);
        repeat (32) @(negedge clk);
        checkOutput("t4_busy_pre", 64'(busy), 64'd1);
        @(negedge clk);
        checkOutput("t4_busy_post", 64'(busy), 64'd0);
        checkOutput("t4_dec_ch1", 64'(dec), 64'({NDIG{S2}}));
        waitCh(2'd2, "t4_ch2", gap);
        checkOutput("t4_gap2", 64'(gap + 33), 64'd50);
        waitCh(2'd0, "t4_ch0", gap);
        checkOutput("t4_gap3", 64'(gap), 64'd50);
        applyStimulus(2'd2, 1'b0, 1'b1, '0);
        @(negedge clk);
        checkOutput("t4_manual", 64'(ch), 64'd2);
        applyStimulus(2'd3, 1'b0, 1'b1, '0);
        repeat (5) @(negedge clk);
        checkOutput("t4_sel_oob", 64'(ch), 64'd2);
        waitBusy(1'b0, "t4_done");

        // Several strobes during one conversion collapse into one follow-up conversion.
        chv[2] = 100;
        applyStimulus(2'd3, 1'b0, 1'b1, 3'b100);
        repeat (5) @(negedge clk);
        chv[2] = 200;
        applyStimulus(2'd3, 1'b0, 1'b1, 3'b100);
        repeat (5) @(negedge clk);
        chv[2] = 300;
        applyStimulus(2'd3, 1'b0, 1'b1, 3'b100);
        repeat (5) @(negedge clk);
        chv[2] = 400;
        applyStimulus(2'd3, 1'b0, 1'b1, 3'b100);
        waitBusy(1'b0, "t5_first");
        checkOutput("t5_dec100", 64'(dec), 64'({BL, BL, BL, S1, S0, S0}));
        @(negedge clk);
        checkOutput("t5_reload", 64'(busy), 64'd1);
        waitBusy(1'b0, "t5_second");
        checkOutput("t5_dec400", 64'(dec), 64'({BL, BL, BL, S4, S0, S0}));
        cnt = 0;
        repeat (40) begin @(negedge clk); if (busy) cnt++; end
        checkOutput("t5_no_third", 64'(cnt), 64'd0);

        chv[1] = 555; chv[2] = 888;
        applyStimulus(2'd3, 1'b0, 1'b1, 3'b100);
        repeat (10) @(negedge clk);
        applyStimulus(2'd1, 1'b0, 1'b1, '0);
        seen_old = 0;
        repeat (60) begin @(negedge clk); if (dec === {BL, BL, BL, S8, S8, S8}) seen_old = 1; end
        checkOutput("t5_abort", 64'(seen_old), 64'd0);
        checkOutput("t5_dec555", 64'(dec), 64'({BL, BL, BL, S5, S5, S5}));

        // Reset in the middle of a conversion.
        chv[1] = 12345;
        applyStimulus(2'd1, 1'b0, 1'b1, 3'b010);
        repeat (9) @(negedge clk);
        rst = 1;
        applyStimulus(2'd0, 1'b0, 1'b1, '0);
        @(negedge clk);
        checkOutput("t6_dec", 64'(dec), 64'({NDIG{BL}}));
        checkOutput("t6_busy", 64'(busy), 64'd0);
        checkOutput("t6_ch", 64'(ch), 64'd0);
        checkOutput("t6_ovf", 64'(ovf), 64'd0);
        rst = 0;
        cnt = 0;
        repeat (40) begin @(negedge clk); if (busy) cnt++; end
        checkOutput("t6_busy_len", 64'(cnt), 64'd33);
        checkOutput("t6_dec111", 64'(dec), 64'({BL, BL, BL, S1, S1, S1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
